// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: register file, jump redirect, print FIFO, halt latch, retire counter
// Optional write-through read bypass: define WB_BYPASS_EN.
module wb_stage #(
    parameter int PRINT_DEPTH = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x2_valid,
    input  logic [15:0]      x2_ins,
    input  logic [15:0]      x2_pc,
    input  logic [15:0]      x2_result,
    output logic             wb_stall,
    input  logic [3:0]       rd_addr_a,
    output logic [15:0]      rd_data_a,
    input  logic [3:0]       rd_addr_b,
    output logic [15:0]      rd_data_b,
    output logic             wb_flush,
    output logic [15:0]      wb_target,
    output logic             print_valid,
    output logic [7:0]       print_data,
    input  logic             print_ready,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = $clog2(PRINT_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(PRINT_DEPTH);

    logic [15:0]   regs [16];
    logic [7:0]    fifo [PRINT_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          halt_latched;

    logic [3:0]  op;
    logic [3:0]  rt;
    logic        is_writer;
    logic        is_jump;
    logic        is_halt;
    logic        full;
    logic        pop;
    logic        accept;
    logic        push;
    logic        mispredict;
    logic [15:0] next_pc;
    logic        unused_bits;

    assign op          = x2_ins[15:12];
    assign rt          = x2_ins[3:0];
    // subcode only distinguishes non-writing opcodes, so writeback never needs it
    assign unused_bits = ^x2_ins[11:4];

    assign is_writer = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) ||
                       (op == 4'h3) || (op == 4'h7);
    assign is_jump   = (op == 4'h6);
    assign is_halt   = (op == 4'hf);

    assign full        = (count == FULL_CNT);
    assign print_valid = (count != '0);
    assign pop         = print_valid & print_ready;
    assign print_data  = print_valid ? fifo[rd_ptr] : 8'h00;

    // a pop in the same cycle frees the slot, so a console write to a full FIFO still goes in
    assign wb_stall = x2_valid & is_writer & (rt == 4'h0) & full & ~pop;
    assign accept   = x2_valid & ~wb_stall & ~wb_flush & ~halt_latched;
    assign push     = accept & is_writer & (rt == 4'h0);

    assign next_pc    = x2_pc + 16'd2;
    assign mispredict = accept & is_jump & (x2_result != next_pc);

    assign halted = halt_latched & (count == '0);

    always_comb begin
        rd_data_a = (rd_addr_a == 4'h0) ? 16'h0000 : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == 4'h0) ? 16'h0000 : regs[rd_addr_b];
`ifdef WB_BYPASS_EN
        if (accept && is_writer && (rt != 4'h0) && (rt == rd_addr_a)) begin
            rd_data_a = x2_result;
        end
        if (accept && is_writer && (rt != 4'h0) && (rt == rd_addr_b)) begin
            rd_data_b = x2_result;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_latched <= 1'b0;
            wb_flush     <= 1'b0;
            wb_target    <= '0;
            retired      <= '0;
        end else begin
            wb_flush <= mispredict;
            if (mispredict) begin
                wb_target <= x2_result;
            end
            if (accept) begin
                retired <= retired + CNT_W'(1);
                if (is_writer && (rt != 4'h0)) begin
                    regs[rt] <= x2_result;
                end
                if (is_halt) begin
                    halt_latched <= 1'b1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage only; print_valid masks stale entries so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= x2_result[7:0];
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a queue-based reference model
module tb_wb_stage;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        x2_valid;
    logic [15:0] x2_ins;
    logic [15:0] x2_pc;
    logic [15:0] x2_result;
    logic        wb_stall;
    logic [3:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        wb_flush;
    logic [15:0] wb_target;
    logic        print_valid;
    logic [7:0]  print_data;
    logic        print_ready;
    logic        halted;
    logic [31:0] retired;

    wb_stage #(.PRINT_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .x2_valid(x2_valid), .x2_ins(x2_ins), .x2_pc(x2_pc),
        .x2_result(x2_result), .wb_stall(wb_stall), .rd_addr_a(rd_addr_a),
        .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .wb_flush(wb_flush), .wb_target(wb_target), .print_valid(print_valid),
        .print_data(print_data), .print_ready(print_ready), .halted(halted),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [15:0] m_regs [16];
    logic [7:0]  m_q [$];
    logic        m_halt;
    logic        m_flush;
    logic [15:0] m_target;
    logic [31:0] m_retired;
    logic        m_pop, m_stall, m_acc, m_writer;
    logic [7:0]  dut_popped [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] addr);
        logic [15:0] v;
        v = (addr == 4'h0) ? 16'h0000 : m_regs[addr];
`ifdef WB_BYPASS_EN
        if (m_acc && m_writer && addr != 4'h0 && x2_ins[3:0] == addr) v = x2_result;
`endif
        return v;
    endfunction

    // settle inputs, predict this cycle's outputs from the model, compare
    task automatic eval();
        logic [3:0] op;
        #3;
        op       = x2_ins[15:12];
        m_writer = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
        m_pop    = (m_q.size() != 0) && print_ready;
        m_stall  = x2_valid && m_writer && (x2_ins[3:0] == 4'h0) && (m_q.size() == DEPTH) && !m_pop;
        m_acc    = x2_valid && !m_stall && !m_flush && !m_halt;
        check("wb_stall", 32'(wb_stall), 32'(m_stall));
        check("print_valid", 32'(print_valid), 32'(m_q.size() != 0));
        check("print_data", 32'(print_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check("rd_data_a", 32'(rd_data_a), 32'(model_read(rd_addr_a)));
        check("rd_data_b", 32'(rd_data_b), 32'(model_read(rd_addr_b)));
        check("wb_flush", 32'(wb_flush), 32'(m_flush));
        if (m_flush) check("wb_target", 32'(wb_target), 32'(m_target));
        check("halted", 32'(halted), 32'(m_halt && m_q.size() == 0));
        check("retired", retired, m_retired);
        if (print_valid && print_ready) dut_popped.push_back(print_data);
    endtask

    task automatic tick();
        logic [3:0] op;
        logic [3:0] rt;
        @(posedge clk);
        op = x2_ins[15:12];
        rt = x2_ins[3:0];
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
            m_q.delete();
            m_halt = 1'b0;
            m_flush = 1'b0;
            m_target = 16'h0;
            m_retired = 32'h0;
        end else begin
            if (m_pop) void'(m_q.pop_front());
            m_flush = 1'b0;
            if (m_acc) begin
                m_retired = m_retired + 1;
                if (m_writer && rt != 0) m_regs[rt] = x2_result;
                if (m_writer && rt == 0) m_q.push_back(x2_result[7:0]);
                if (op == 4'h6 && x2_result != 16'(x2_pc + 16'd2)) begin
                    m_flush = 1'b1;
                    m_target = x2_result;
                end
                if (op == 4'hf) m_halt = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        eval();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x2_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic present(input logic [3:0] op, input logic [3:0] rt, input logic [15:0] pc,
                           input logic [15:0] res);
        x2_valid = 1'b1;
        x2_ins = {op, 4'h0, 4'h0, rt};
        x2_pc = pc;
        x2_result = res;
    endtask

    initial begin
        string expect_str;
        rst = 1'b1; x2_valid = 1'b0; x2_ins = 16'h0; x2_pc = 16'h0; x2_result = 16'h0;
        rd_addr_a = 4'h0; rd_addr_b = 4'h0; print_ready = 1'b0;
        tick();
        rst = 1'b0;

        // reset state
        eval();
        check("rst_stall", 32'(wb_stall), 32'h0);
        check("rst_flush", 32'(wb_flush), 32'h0);
        check("rst_target", 32'(wb_target), 32'h0);
        check("rst_pvalid", 32'(print_valid), 32'h0);
        check("rst_pdata", 32'(print_data), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_retired", retired, 32'h0);
        tick();

        // add rt=3 then read back
        present(4'h0, 4'd3, 16'h0, 16'h1234);
        cycle();
        x2_valid = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd0;
        eval();
        check("add_r3", 32'(rd_data_a), 32'h1234);
        check("add_r0", 32'(rd_data_b), 32'h0);
        check("add_retired", retired, 32'd1);
        tick();

        // same-cycle read of a register being written
        present(4'h7, 4'd5, 16'h0, 16'hbeef);
        rd_addr_a = 4'd5;
        eval();
`ifdef WB_BYPASS_EN
        check("ld_same_cycle", 32'(rd_data_a), 32'hbeef);
`else
        check("ld_same_cycle", 32'(rd_data_a), 32'h0);
`endif
        tick();
        x2_valid = 1'b0;
        eval();
        check("ld_next_cycle", 32'(rd_data_a), 32'hbeef);
        tick();

        // jump redirect, wrong-path drop, jump without redirect
        do_reset();
        present(4'h6, 4'h0, 16'h0010, 16'h0040);
        cycle();
        present(4'h0, 4'd2, 16'h0, 16'h5555);
        rd_addr_a = 4'd2;
        eval();
        check("jmp_flush", 32'(wb_flush), 32'h1);
        check("jmp_target", 32'(wb_target), 32'h0040);
        tick();
        x2_valid = 1'b0;
        eval();
        check("jmp_flush_once", 32'(wb_flush), 32'h0);
        check("jmp_drop_retired", retired, 32'd1);
        check("jmp_drop_r2", 32'(rd_data_a), 32'h0);
        tick();
        present(4'h6, 4'h0, 16'h0010, 16'h0012);
        cycle();
        x2_valid = 1'b0;
        eval();
        check("jmp_noflush", 32'(wb_flush), 32'h0);
        tick();

        // print FIFO fill, stall, pop-and-push on full
        do_reset();
        dut_popped.delete();
        print_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            present(4'h0, 4'h0, 16'h0, 16'(8'h41 + i));
            cycle();
        end
        present(4'h0, 4'h0, 16'h0, 16'h0045);
        eval();
        check("fifo_full_stall", 32'(wb_stall), 32'h1);
        tick();
        print_ready = 1'b1;
        eval();
        check("fifo_pop_push", 32'(wb_stall), 32'h0);
        tick();
        x2_valid = 1'b0;
        for (int i = 0; i < 20 && print_valid; i++) cycle();
        check("fifo_count", 32'(dut_popped.size()), 32'd5);
        expect_str = "ABCDE";
        for (int i = 0; i < 5 && i < dut_popped.size(); i++)
            check("fifo_order", 32'(dut_popped[i]), 32'(expect_str[i]));

        // halt waits for the FIFO to drain
        do_reset();
        dut_popped.delete();
        print_ready = 1'b0;
        present(4'h0, 4'h0, 16'h0, 16'h0048);
        cycle();
        present(4'hf, 4'h0, 16'h0, 16'h0);
        cycle();
        present(4'h0, 4'd1, 16'h0, 16'h7777);
        cycle();
        x2_valid = 1'b0; rd_addr_a = 4'd1;
        eval();
        check("halt_pending", 32'(halted), 32'h0);
        check("halt_retired", retired, 32'd2);
        check("halt_r1", 32'(rd_data_a), 32'h0);
        tick();
        print_ready = 1'b1;
        for (int i = 0; i < 10 && !halted; i++) cycle();
        eval();
        check("halt_done", 32'(halted), 32'h1);
        check("halt_retired2", retired, 32'd2);
        check("halt_drained", 32'(dut_popped.size()), 32'd1);
        tick();

        // reset with FIFO entries and a pending flush
        do_reset();
        print_ready = 1'b0;
        present(4'h1, 4'd4, 16'h0, 16'h0099);
        cycle();
        for (int i = 0; i < 3; i++) begin
            present(4'h0, 4'h0, 16'h0, 16'(8'h30 + i));
            cycle();
        end
        present(4'h6, 4'h0, 16'h0100, 16'h0200);
        cycle();
        x2_valid = 1'b0;
        eval();
        check("pre_rst_flush", 32'(wb_flush), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        eval();
        check("mid_rst_pvalid", 32'(print_valid), 32'h0);
        check("mid_rst_flush", 32'(wb_flush), 32'h0);
        tick();
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            rd_addr_b = 4'(15 - a);
            eval();
            check("mid_rst_reg", 32'(rd_data_a), 32'h0);
            tick();
        end

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [3:0] op;
            logic [3:0] rt;
            logic [15:0] pc;
            r = $urandom_range(0, 99);
            if (r < 45)      op = 4'($urandom_range(0, 4) == 4 ? 7 : $urandom_range(0, 3));
            else if (r < 60) op = 4'h6;
            else if (r < 62) op = 4'hf;
            else             op = 4'($urandom_range(0, 15));
            rt = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            pc = 16'($urandom);
            present(op, rt, pc, 16'($urandom));
            if (op == 4'h6 && $urandom_range(0, 1) == 0) x2_result = pc + 16'd2;
            x2_ins[11:4] = 8'($urandom);
            x2_valid = ($urandom_range(0, 3) != 0);
            rd_addr_a = 4'($urandom);
            rd_addr_b = 4'($urandom);
            print_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 9) == 0);
            cycle();
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
